// File: rtl/onehot_req_capture_if.sv
// Grant handshake between the request capture stage and its consumer (the 4x2 encoder).
// The capture stage drives the one-hot grant and valid; the consumer returns ack.
interface onehot_req_capture_if;
    logic [3:0] q;
    logic       valid;
    logic       ack;

    modport master (
        output q,
        output valid,
        input  ack
    );

    modport slave (
        input  q,
        input  valid,
        output ack
    );
endinterface

// File: rtl/onehot_req_capture.sv
// Synchronise, debounce and latch rising edges on four request lines, then grant them one at a
// time as a one-hot word. Define ROUND_ROBIN_EN for round-robin, else fixed priority (ch3 highest).
module onehot_req_capture #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           raw,
    onehot_req_capture_if.master bus,
    output logic [3:0]           pending,
    output logic                 overflow
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       s1_q, s2_q;
    logic [3:0]       stable_q, stable_d;
    logic [3:0]       stable_prev_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic [3:0]       q_q, q_d;
    logic             valid_q, valid_d;
    logic [3:0]       ev;
    logic [3:0]       clr;
    logic [3:0]       sel;

    // Debounce: the stable level flips only after DB_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = '0;
            if (s2_q[k] != stable_q[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    stable_d[k] = s2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    assign ev  = stable_q & ~stable_prev_q;
    assign clr = (valid_q && bus.ack) ? q_q : 4'b0000;

`ifdef ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_idx;
    logic [1:0] idx;

    always_comb begin
        sel     = 4'b0000;
        sel_idx = ptr_q;
        idx     = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_q + 2'(i);
            if (sel == 4'b0000 && pending_q[idx]) begin
                sel     = 4'(1) << idx;
                sel_idx = idx;
            end
        end
    end
`else
    // Ascending scan, last hit wins: channel 3 dominates.
    always_comb begin
        sel = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (pending_q[k]) begin
                sel = 4'(1) << k;
            end
        end
    end
`endif

    always_comb begin
        // A fresh event on the channel being accepted wins over the clear.
        pending_d  = (pending_q & ~clr) | ev;
        overflow_d = |(ev & pending_q & ~clr);
        q_d        = q_q;
        valid_d    = valid_q;
`ifdef ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        if (valid_q && bus.ack) begin
            valid_d = 1'b0;
            q_d     = 4'b0000;
        end else if (!valid_q && pending_q != 4'b0000) begin
            valid_d = 1'b1;
            q_d     = sel;
`ifdef ROUND_ROBIN_EN
            ptr_d   = sel_idx;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q          <= '0;
            s2_q          <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            pending_q     <= '0;
            overflow_q    <= 1'b0;
            q_q           <= '0;
            valid_q       <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
`ifdef ROUND_ROBIN_EN
            ptr_q         <= 2'd3;
`endif
        end else begin
            s1_q          <= raw;
            s2_q          <= s1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            q_q           <= q_d;
            valid_q       <= valid_d;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
`ifdef ROUND_ROBIN_EN
            ptr_q         <= ptr_d;
`endif
        end
    end

    assign bus.q     = q_q;
    assign bus.valid = valid_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule
